// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with writeback source select and load extension
// Optional build macro: WB_LOAD_EXT_EN enables RV32I byte/halfword load extraction.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] dmem,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [RA_W-1:0] rd_in,
  input  logic            reg_write,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] sel_val;

`ifdef WB_LOAD_EXT_EN
  // Pad to at least 32 bits so all four byte lanes are addressable for narrow XLEN.
  localparam int PW = (XLEN < 32) ? 32 : XLEN;
  logic [PW-1:0] dmem_pad;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  always_comb begin
    dmem_pad = PW'(dmem);
    byte_v   = dmem_pad[{addr_lo, 3'b000} +: 8];
    half_v   = dmem_pad[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   ld_val = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  ld_val = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   ld_val = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  ld_val = {{(XLEN-16){1'b0}}, half_v};
      default: ld_val = dmem;
    endcase
  end
`else
  logic unused_ld;
  assign unused_ld = ^{funct3, addr_lo, F3_LB, F3_LH, F3_LBU, F3_LHU};
  assign ld_val    = dmem;
`endif

  always_comb begin
    sel_val = alu;
    case (sel)
      2'd0:    sel_val = alu;
      2'd1:    sel_val = ld_val;
      2'd2:    sel_val = pc + XLEN'(4);
      default: sel_val = imm;
    endcase
  end

  logic            valid_d, valid_q;
  logic            we_d, we_q;
  logic [RA_W-1:0] rd_d, rd_q;
  logic [XLEN-1:0] data_d, data_q;

  // Flush beats stall; on flush the payload holds and only valid/we are dropped.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      we_d    = in_valid & reg_write & (rd_in != '0);
      rd_d    = rd_in;
      data_d  = sel_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_we    = we_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised MEM/WB pipeline register and writeback-select stage for the pipelined RISC-V core. It captures the memory-stage results on each clock and selects the register-file write value from four sources: ALU, data memory, PC+4 and immediate. It also performs RV32I load byte/halfword extraction with sign or zero extension. It sits between the memory stage and the register-file write port and supports stall and flush.

## Interface
Parameters:
- XLEN, 32, datapath width; must be ≥ 16 and a multiple of 8
- RA_W, 5, register address width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  memory-stage instruction is valid
- stall  input  1  hold the MEM/WB register contents
- flush  input  1  invalidate the MEM/WB register contents
- sel  input  2  writeback source: 0 ALU (R/I-arith), 1 data memory (loads), 2 PC+4 (JAL/JALR), 3 immediate (LUI)
- alu  input  XLEN  ALU result
- dmem  input  XLEN  raw data-memory read word
- pc  input  XLEN  instruction PC
- imm  input  XLEN  decoded immediate
- funct3  input  3  load type
- addr_lo  input  2  low bits of the load address (alu[1:0] from the memory stage)
- rd_in  input  RA_W  destination register
- reg_write  input  1  instruction writes rd
- wb_valid  output  1  registered instruction valid
- wb_we  output  1  register-file write enable
- wb_rd  output  RA_W  register-file write address
- wb_data  output  XLEN  register-file write data

## Operation
- The next-state result is computed combinationally from the inputs and registered; all outputs come from flops.
- Source select:
  - sel=0 → alu
  - sel=1 → load-extended dmem
  - sel=2 → pc+4, truncated to XLEN (0xFFFFFFFC → 0x00000000)
  - sel=3 → imm
- Load extension (sel=1):
  - funct3 000 (LB): byte lane addr_lo, sign-extended
  - funct3 100 (LBU): byte lane addr_lo, zero-extended
  - funct3 001 (LH): half lane addr_lo[1], sign-extended
  - funct3 101 (LHU): half lane addr_lo[1], zero-extended
  - funct3 010 (LW) and all other codes: dmem unmodified
  - Lane 0 is bits [7:0]/[15:0]. addr_lo[0] is ignored for halfwords; misalignment is not trapped here.
- wb_we = wb_valid & registered reg_write & (wb_rd ≠ 0), so writes to x0 are always suppressed.
- Capture priority at each clock edge, highest first:
  - rst_n=0 → every register cleared
  - flush=1 → wb_valid←0; other fields may update but wb_we must be 0
  - stall=1 → all registers hold
  - otherwise → wb_valid←in_valid and all fields load
- When in_valid=0, wb_we must be 0 regardless of reg_write.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset value of every output: wb_valid=0, wb_we=0, wb_rd=0, wb_data=0.
- Reset is synchronous. Asserting rst_n=0 mid-stream clears the stage at the next edge, and any pending write is dropped.
- Flush and stall in the same cycle: flush wins and the stage empties.
- While stall is held for k cycles, the outputs are stable for k cycles and wb_we stays asserted if it was asserted, so the register file must tolerate repeated identical writes.
- Throughput is one instruction per cycle when stall=0.

## Configuration
- WB_LOAD_EXT_EN defined: load extension behaves as described under Operation.
- WB_LOAD_EXT_EN undefined: sel=1 passes dmem unmodified, and funct3 and addr_lo are ignored. This is the word-only load build.
- Source select, the pipeline register, stall/flush and x0 suppression are identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → all outputs 0. Release rst_n, then drive sel=0, alu=0x12345678, rd_in=5, reg_write=1 → the next cycle gives wb_data=0x12345678, wb_rd=5, wb_we=1.
- Loads with WB_LOAD_EXT_EN, dmem=0x80F17F00:
  - LB, addr_lo=2 → 0xFFFFFFF1
  - LBU, addr_lo=2 → 0x000000F1
  - LH, addr_lo=0 → 0x00007F00
  - LH, addr_lo=3 → 0xFFFF80F1
  - LW → 0x80F17F00
  - Without the macro, LB with addr_lo=2 → 0x80F17F00.
- Sources: sel=2 with pc=0x00000100 → 0x00000104. sel=2 with pc=0xFFFFFFFC → 0x00000000. sel=3 with imm=0xABCDE000 → 0xABCDE000.
- x0 suppression: rd_in=0, reg_write=1, in_valid=1 → wb_valid=1, wb_we=0. in_valid=0 with rd_in=7 → wb_we=0.
- Stall/flush: load instruction A, assert stall for 3 cycles while the inputs change → outputs hold A. Assert stall and flush together → wb_valid=0 and wb_we=0 on the next cycle.
- Back-to-back: 4 consecutive valid instructions with sel=0,1,2,3 → 4 consecutive distinct correct wb_data values with no bubbles.
